// File: rtl/intdispatch_pkg.sv
// Shared types and constants for the interrupt dispatch block.
package intdispatch_pkg;

  localparam int          WAIT_MC_DEFAULT = 2;
  localparam logic [15:0] VEC_CANCEL      = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PUSHH,
    ST_PUSHL,
    ST_JUMP
  } disp_state_t;

endpackage

// File: rtl/intdispatch_imectl.sv
// Interrupt master enable, delayed-EI pending flag and HALT sleep flag.
module intdispatch_imectl (
  input  logic clockgb,
  input  logic resetn,
  input  logic mcycle,
  input  logic boundary,
  input  logic ei,
  input  logic di,
  input  logic reti,
  input  logic halt,
  input  logic intreq,
  input  logic idle,
  input  logic start,
  output logic ime,
  output logic halted
);

  logic ei_pend;
  logic ime_nx;
  logic ei_pend_nx;
  logic halted_nx;

  // NOTE: every next-state variable is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    ime_nx     = ime;
    ei_pend_nx = ei_pend;
    halted_nx  = halted;
    if (start) begin
      ime_nx     = 1'b0;
      ei_pend_nx = 1'b0;
      halted_nx  = 1'b0;
    end else if (idle) begin
      if (halted && intreq) halted_nx = 1'b0;
      // EI takes effect one instruction late: promote at the boundary after it.
      if (boundary && ei_pend) begin
        ime_nx     = 1'b1;
        ei_pend_nx = 1'b0;
      end
      if (ei)   ei_pend_nx = 1'b1;
      if (reti) ime_nx     = 1'b1;
      if (di) begin
        ime_nx     = 1'b0;
        ei_pend_nx = 1'b0;
      end
      if (halt && !intreq) halted_nx = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      ime     <= 1'b0;
      ei_pend <= 1'b0;
      halted  <= 1'b0;
    end else if (mcycle) begin
      ime     <= ime_nx;
      ei_pend <= ei_pend_nx;
      halted  <= halted_nx;
    end
  end

endmodule

// File: rtl/intdispatch.sv
// CPU-side interrupt dispatcher: IME/HALT control plus the push-PC-and-jump sequence.
module intdispatch
  import intdispatch_pkg::*;
#(
  parameter int WAIT_MC = WAIT_MC_DEFAULT
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic        mcycle,
  input  logic        boundary,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        halt,
  input  logic        intreq,
  input  logic [15:0] intaddress,
  output logic        intack,
  input  logic [15:0] pc_in,
  input  logic [15:0] sp_in,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [15:0] sp_out,
  output logic        sp_load,
  output logic [15:0] address,
  output logic [7:0]  outdata,
  output logic        store,
  output logic        busy,
  output logic        ime,
  output logic        halted
);

  disp_state_t state;
  disp_state_t state_nx;
  logic [3:0]  wait_cnt;
  logic [15:0] pc_q;
  logic [15:0] sp_q;
  logic        idle;
  logic        start;

  assign idle  = (state == ST_IDLE);
  // A sleeping core has no boundary; an interrupt with IME set dispatches straight from HALT.
  assign start = idle && mcycle && ime && intreq && (boundary || halted);
  assign busy  = !idle || halted || start;

  intdispatch_imectl u_imectl (
    .clockgb  (clockgb),
    .resetn   (resetn),
    .mcycle   (mcycle),
    .boundary (boundary),
    .ei       (ei),
    .di       (di),
    .reti     (reti),
    .halt     (halt),
    .intreq   (intreq),
    .idle     (idle),
    .start    (start),
    .ime      (ime),
    .halted   (halted)
  );

  always_comb begin
    state_nx = state;
    address  = '0;
    outdata  = '0;
    store    = 1'b0;
    sp_out   = '0;
    sp_load  = 1'b0;
    pc_out   = '0;
    pc_load  = 1'b0;
    intack   = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_WAIT;
      ST_WAIT:  if (wait_cnt == 4'(WAIT_MC - 1)) state_nx = ST_PUSHH;
      ST_PUSHH: begin
        address  = sp_q - 16'd1;
        outdata  = pc_q[15:8];
        sp_out   = sp_q - 16'd1;
        store    = mcycle;
        sp_load  = mcycle;
        state_nx = ST_PUSHL;
      end
      ST_PUSHL: begin
        address  = sp_q - 16'd2;
        outdata  = pc_q[7:0];
        sp_out   = sp_q - 16'd2;
        store    = mcycle;
        sp_load  = mcycle;
        state_nx = ST_JUMP;
      end
      // The pushes may have cleared the request; only this sample decides the vector.
      ST_JUMP: begin
        pc_out   = intreq ? intaddress : VEC_CANCEL;
        pc_load  = mcycle;
        intack   = mcycle && intreq;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      pc_q     <= '0;
      sp_q     <= '0;
    end else if (mcycle) begin
      state    <= state_nx;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (start) begin
        pc_q <= pc_in;
        sp_q <= sp_in;
      end
    end
  end

endmodule
